// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder. It tracks make and break state for NUM_KEYS configurable keys,
// including E0-extended codes. It drives held levels plus one-cycle press and release pulses.
module ps2_key_decoder #(
   parameter int unsigned             NUM_KEYS       = 4,
   parameter logic [NUM_KEYS*9-1:0]   KEY_CODES      = {9'h172, 9'h175, 9'h174, 9'h16B},
   parameter int unsigned             TIMEOUT_CYCLES = 500000
) (
   input  logic                i_clock,
   input  logic                i_resetn,
   input  logic [7:0]          i_key_data,
   input  logic                i_key_pressed,
   input  logic                i_clear,
   output logic [NUM_KEYS-1:0] o_key_held,
   output logic [NUM_KEYS-1:0] o_key_press,
   output logic [NUM_KEYS-1:0] o_key_release,
   output logic                o_any_held,
   output logic [8:0]          o_last_code
);

   localparam int unsigned     CntW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [CntW-1:0]     r_timer;
   logic [CntW-1:0]     w_timer_next;
   logic [NUM_KEYS-1:0] r_held;
   logic [NUM_KEYS-1:0] r_press;
   logic [NUM_KEYS-1:0] r_release;
   logic                r_any_held;
   logic [8:0]          r_last_code;

   logic                w_is_e0;
   logic                w_is_f0;
   logic                w_done;
   logic                w_brk;
   logic [8:0]          w_code;
   logic [NUM_KEYS-1:0] w_match;
   logic [NUM_KEYS-1:0] w_hit;
   logic [NUM_KEYS-1:0] w_held_next;
   logic [NUM_KEYS-1:0] w_press_next;
   logic [NUM_KEYS-1:0] w_release_next;

   assign w_is_e0 = (i_key_data == 8'hE0);
   assign w_is_f0 = (i_key_data == 8'hF0);

   // Prefix FSM: decide the next state and whether this byte completes a make or break.
   always_comb begin
      w_state_next = r_state;
      w_done       = 1'b0;
      w_brk        = 1'b0;
      w_code       = {1'b0, i_key_data};
      if (i_key_pressed) begin
         unique case (r_state)
            StIdle: begin
               if (w_is_e0)      w_state_next = StExt;
               else if (w_is_f0) w_state_next = StBrk;
               else              w_done       = 1'b1;
            end
            StExt: begin
               if (w_is_f0)      w_state_next = StExtBrk;
               else if (w_is_e0) w_state_next = StExt;
               else begin
                  w_done       = 1'b1;
                  w_code       = {1'b1, i_key_data};
                  w_state_next = StIdle;
               end
            end
            StBrk: begin
               if (w_is_f0)      w_state_next = StBrk;
               else if (w_is_e0) w_state_next = StExtBrk;
               else begin
                  w_done       = 1'b1;
                  w_brk        = 1'b1;
                  w_state_next = StIdle;
               end
            end
            StExtBrk: begin
               if (w_is_e0 || w_is_f0) w_state_next = StExtBrk;
               else begin
                  w_done       = 1'b1;
                  w_brk        = 1'b1;
                  w_code       = {1'b1, i_key_data};
                  w_state_next = StIdle;
               end
            end
         endcase
      end else if ((r_state != StIdle) && (r_timer == CntMax)) begin
         // A stale prefix is dropped only when no byte arrives on the expiry cycle.
         w_state_next = StIdle;
      end
   end

   // Timer counts idle cycles while a prefix is pending. It restarts on any accepted byte.
   always_comb begin
      w_timer_next = '0;
      if (!i_key_pressed && (r_state != StIdle) && (r_timer != CntMax)) begin
         w_timer_next = r_timer + CntW'(1);
      end
   end

   // Compare the full 9-bit code against every key slot. Duplicate codes update all matching slots.
   always_comb begin
      w_match = '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
         w_match[i] = (KEY_CODES[9*i +: 9] == w_code);
      end
      w_hit          = w_done ? w_match : '0;
      w_held_next    = w_brk ? (r_held & ~w_hit) : (r_held | w_hit);
      w_press_next   = w_brk ? '0 : (w_hit & ~r_held);
      w_release_next = w_brk ? (w_hit & r_held) : '0;
   end

   // State, timer and registered outputs. Clear wipes key state quietly but keeps last_code.
   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state     <= StIdle;
         r_timer     <= '0;
         r_held      <= '0;
         r_press     <= '0;
         r_release   <= '0;
         r_any_held  <= 1'b0;
         r_last_code <= '0;
      end else if (i_clear) begin
         r_state    <= StIdle;
         r_timer    <= '0;
         r_held     <= '0;
         r_press    <= '0;
         r_release  <= '0;
         r_any_held <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_timer    <= w_timer_next;
         r_held     <= w_held_next;
         r_press    <= w_press_next;
         r_release  <= w_release_next;
         r_any_held <= |w_held_next;
         if (w_done) r_last_code <= w_code;
      end
   end

   assign o_key_held    = r_held;
   assign o_key_press   = r_press;
   assign o_key_release = r_release;
   assign o_any_held    = r_any_held;
   assign o_last_code   = r_last_code;

endmodule
